// File: rtl/sync_fifo_pkg.sv
// Shared constants for the synchronous FIFO: default geometry and the
// helpers that size its pointers and occupancy counter.
package sync_fifo_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 16;

    // Pointer width: addresses exactly DEPTH entries (DEPTH is a power of two).
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Counter width: one extra bit so that count == DEPTH is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem_sdp_ram_core.sv
// sdp_ram_core: single-clock simple dual-port storage with one write port
// and one registered read port. The read register holds its value when no
// read is requested, so downstream sees the last word read.
module sdp_ram_core #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Storage write port.
    // NOTE: the array has no reset on purpose; clearing it would turn a RAM
    // into a flop bank, and the pointers already make stale words unreachable.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Registered read port; a same-address write in this cycle is not seen.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: single-clock FIFO. Pointers, occupancy, status flags and
// error flags live here; the words themselves live in sdp_ram_core.
// Optional feature: define SYNC_FIFO_ERR_EN to enable the sticky
// err_ovf/err_udf flags (otherwise they are tied low and clr_err is unused).
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic                        rd_en,
    output logic [WIDTH-1:0]            rd_data,
    output logic                        rd_valid,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [cnt_width(DEPTH)-1:0] count,
    input  logic                        clr_err,
    output logic                        err_ovf,
    output logic                        err_udf
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_empty;
    logic          r_almost_full;
    logic          r_almost_empty;
    logic          r_rd_valid;

    logic          w_rd_accept;
    logic          w_wr_accept;
    logic [CW-1:0] w_count_nxt;

    // Requests are ignored while reset is asserted. A write into a full FIFO
    // is allowed only when a read frees a slot in the same cycle.
    assign w_rd_accept = rst_n && rd_en && !r_empty;
    assign w_wr_accept = rst_n && wr_en && (!r_full || w_rd_accept);

    // Next occupancy from the two accepts.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_accept, w_rd_accept})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointer, occupancy and flag registers; flags derive from the same
    // next-count value so they always agree with count.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= (AF_LEVEL == 0);
            r_almost_empty <= 1'b1;
            r_rd_valid     <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == DEPTH_C);
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= AF_C);
            r_almost_empty <= (w_count_nxt <= AE_C);
            r_rd_valid     <= w_rd_accept;
        end
    end

    sdp_ram_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_accept),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (wr_data),
        .i_rd_en   (w_rd_accept),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (rd_data)
    );

`ifdef SYNC_FIFO_ERR_EN
    logic w_ovf_evt;
    logic w_udf_evt;
    logic r_err_ovf;
    logic r_err_udf;

    assign w_ovf_evt = rst_n && wr_en && !w_wr_accept;
    assign w_udf_evt = rst_n && rd_en && r_empty;

    // Sticky error flags; a new event outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_ovf <= 1'b0;
            r_err_udf <= 1'b0;
        end else begin
            if (w_ovf_evt) begin
                r_err_ovf <= 1'b1;
            end else if (clr_err) begin
                r_err_ovf <= 1'b0;
            end
            if (w_udf_evt) begin
                r_err_udf <= 1'b1;
            end else if (clr_err) begin
                r_err_udf <= 1'b0;
            end
        end
    end

    assign err_ovf = r_err_ovf;
    assign err_udf = r_err_udf;
`else
    logic w_unused_clr;

    assign w_unused_clr = clr_err;
    assign err_ovf      = 1'b0;
    assign err_udf      = 1'b0;
`endif

    assign rd_valid     = r_rd_valid;
    assign full         = r_full;
    assign empty        = r_empty;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign count        = r_count;

endmodule

// File: tb/tb_sync_fifo_mem.sv
// Testbench for sync_fifo_mem (WIDTH=8, DEPTH=16, default levels).
// Stimulus pushes expected read words into a scoreboard queue; an
// independent monitor pops and compares whenever rd_valid is seen.
module tb_sync_fifo_mem;

    localparam int DEPTH = 16;
    localparam int CW    = 5;
`ifdef SYNC_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          wr_en   = 1'b0;
    logic [7:0]    wr_data = '0;
    logic          rd_en   = 1'b0;
    logic          clr_err = 1'b0;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] count;
    logic          err_ovf;
    logic          err_udf;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mdl_q[$];
    int         m_count = 0;
    bit         m_ovf   = 1'b0;
    bit         m_udf   = 1'b0;

    sync_fifo_mem dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .clr_err      (clr_err),
        .err_ovf      (err_ovf),
        .err_udf      (err_udf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Occupancy and flags against the reference model.
    task automatic check_state();
        check("count",        32'(count),        32'(m_count));
        check("full",         32'(full),         32'(m_count == DEPTH));
        check("empty",        32'(empty),        32'(m_count == 0));
        check("almost_full",  32'(almost_full),  32'(m_count >= 14));
        check("almost_empty", 32'(almost_empty), 32'(m_count <= 2));
        check("err_ovf",      32'(err_ovf),      32'(m_ovf));
        check("err_udf",      32'(err_udf),      32'(m_udf));
    endtask

    // One clock of stimulus; updates the model and queues expected reads.
    task automatic drive(input bit w, input logic [7:0] d, input bit r, input bit clr = 1'b0);
        bit rd_acc;
        bit wr_acc;
        @(negedge clk);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clr_err = clr;
        rd_acc = r && (m_count > 0);
        wr_acc = w && ((m_count < DEPTH) || rd_acc);
        if (rd_acc) exp_q.push_back(mdl_q.pop_front());
        if (wr_acc) mdl_q.push_back(d);
        if (wr_acc && !rd_acc) m_count++;
        else if (rd_acc && !wr_acc) m_count--;
        if (ERR_EN) begin
            if (w && !wr_acc) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            if (r && !rd_acc) m_udf = 1'b1;
            else if (clr) m_udf = 1'b0;
        end
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        check_state();
    endtask

    // One-cycle reset with live requests that must be ignored.
    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        wr_data = 8'h77;
        rd_en   = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        mdl_q.delete();
        m_count = 0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        check("rst_count",        32'(count),        32'd0);
        check("rst_empty",        32'(empty),        32'd1);
        check("rst_full",         32'(full),         32'd0);
        check("rst_almost_empty", 32'(almost_empty), 32'd1);
        check("rst_almost_full",  32'(almost_full),  32'd0);
        check("rst_rd_valid",     32'(rd_valid),     32'd0);
        check("rst_rd_data",      32'(rd_data),      32'd0);
        check("rst_err_ovf",      32'(err_ovf),      32'd0);
        check("rst_err_udf",      32'(err_udf),      32'd0);
    endtask

    // Scoreboard monitor: every rd_valid pulse must match the oldest expectation.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_rd_valid: got rd_data 0x%0h with nothing expected at %0t",
                             rd_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", 32'(rd_data), 32'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Fill 0x01..0x10, then an overflow write of 0xFF.
        for (int i = 1; i <= 16; i++) drive(1'b1, 8'(i), 1'b0);
        check("fill_count", 32'(count), 32'd16);
        check("fill_full",  32'(full),  32'd1);
        drive(1'b1, 8'hFF, 1'b0);
        check("ovf_count", 32'(count),   32'd16);
        check("ovf_flag",  32'(err_ovf), 32'(ERR_EN));
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_cleared", 32'(err_ovf), 32'd0);

        // Drain: 0x01..0x10 in order; 0xFF must never appear.
        for (int i = 0; i < 16; i++) drive(1'b0, 8'h00, 1'b1);
        check("drain_empty", 32'(empty), 32'd1);
        drive(1'b0, 8'h00, 1'b0);
        check("rd_valid_single", 32'(rd_valid), 32'd0);
        check("rd_data_hold",    32'(rd_data),  32'h10);

        // Simultaneous write and read while full.
        for (int i = 0; i < 16; i++) drive(1'b1, 8'(8'h21 + i), 1'b0);
        drive(1'b1, 8'hAA, 1'b1);
        check("both_at_full_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        check("aa_read_last", 32'(rd_data), 32'hAA);
        check("aa_empty",     32'(empty),   32'd1);

        // Simultaneous write and read while empty: write only, read underflows.
        drive(1'b1, 8'h55, 1'b1);
        check("udf_rd_valid", 32'(rd_valid), 32'd0);
        check("udf_count",    32'(count),    32'd1);
        check("udf_flag",     32'(err_udf),  32'(ERR_EN));
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        check("udf_cleared", 32'(err_udf), 32'd0);
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        check("udf_beats_clear", 32'(err_udf), 32'(ERR_EN));
        drive(1'b0, 8'h00, 1'b0, 1'b1);

        // 40 writes with interleaved reads; pointers wrap repeatedly.
        for (int i = 0; i < 40; i++) drive(1'b1, 8'(8'h40 + i), (i % 3) != 0);
        for (int k = 0; k < 32 && m_count > 0; k++) drive(1'b0, 8'h00, 1'b1);
        check("wrap_drained", 32'(count), 32'd0);

        // Fill to 7, reset mid-operation, then a read must underflow.
        for (int i = 0; i < 7; i++) drive(1'b1, 8'(8'h80 + i), 1'b0);
        check("pre_rst_count", 32'(count), 32'd7);
        do_reset();
        drive(1'b0, 8'h00, 1'b1);
        check("post_rst_rd_valid", 32'(rd_valid), 32'd0);
        check("post_rst_udf",      32'(err_udf),  32'(ERR_EN));
        drive(1'b0, 8'h00, 1'b0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo_mem.md
SYNC_FIFO_MEM -- requirements
Module: sync_fifo_mem

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (1..256).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries; power of two, >= 4.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, count at or above which almost_full asserts.
REQ-004 SHALL have parameter AE_LEVEL, default 2, count at or below which almost_empty asserts.
REQ-005 SHALL have the following ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- wr_en  in  1  write request.
- wr_data  in  WIDTH  write data.
- rd_en  in  1  read request.
- rd_data  out  WIDTH  read data, registered.
- rd_valid  out  1  rd_data holds a newly read word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy.
- clr_err  in  1  clears sticky error flags.
- err_ovf  out  1  sticky overflow flag.
- err_udf  out  1  sticky underflow flag.

Function
REQ-006 Write accept SHALL be wr_en && (!full || rd_accept); accepted word stored at wr_ptr, wr_ptr increments.
REQ-007 Read accept (rd_accept) SHALL be rd_en && !empty; word at rd_ptr appears on rd_data one cycle later with rd_valid=1 for exactly that cycle; rd_ptr increments.
REQ-008 rd_data SHALL hold its last value when rd_valid=0.
REQ-009 Pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no gap.
REQ-010 count SHALL update in the cycle after the accepts: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-011 full, empty, almost_full and almost_empty SHALL be registered and consistent with count in the same cycle.
REQ-012 A simultaneous write and read when full SHALL be accepted; count stays DEPTH.
REQ-013 When empty, a simultaneous write and read SHALL accept only the write; the read is an underflow. No write-to-read bypass.
REQ-014 wr_en while full without a read accept SHALL be an overflow; data is dropped and storage is unchanged.
REQ-015 rd_en while empty SHALL be an underflow; rd_valid stays 0.

Reset
REQ-016 On rst_n=0 at a clk edge, the block SHALL set: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0), rd_valid=0, rd_data=0, err_ovf=0, err_udf=0.
REQ-017 Storage contents SHALL NOT be reset; reset mid-operation discards all queued words.
REQ-018 Requests in the reset cycle SHALL be ignored.

Configuration
REQ-019 With macro SYNC_FIFO_ERR_EN defined, err_ovf/err_udf SHALL set on an overflow/underflow event and hold until clr_err=1 or reset. A new event in the same cycle as clr_err=1 wins: the flag stays 1.
REQ-020 Without SYNC_FIFO_ERR_EN, err_ovf and err_udf SHALL be tied to 0 and clr_err ignored; the port list is identical in both builds.

Structure
REQ-021 A shared package sync_fifo_pkg SHALL hold the pointer-width and count-width helper constants plus the default WIDTH/DEPTH values.
REQ-022 Storage SHALL be a sub-module sdp_ram_core: a single-clock simple dual-port array with one write port and one registered read port. Control, pointers, count and flags stay in sync_fifo_mem.

Verification (WIDTH=8, DEPTH=16, defaults)
REQ-023 Reset, then write 0x01..0x10 over 16 cycles -> full=1, count=16, almost_full from count 14; one extra write 0xFF is dropped; err_ovf=1 when the macro is defined.
REQ-024 Read 16 words from full -> rd_data is 0x01..0x10 in order, each with a one-cycle rd_valid; then empty=1, almost_empty from count 2.
REQ-025 At full, assert wr_en=1 (0xAA) and rd_en=1 together -> both accepted, count stays 16, 0xAA is read last.
REQ-026 Empty FIFO, wr_en=1 and rd_en=1 together -> rd_valid=0, count=1, err_udf=1 when the macro is defined.
REQ-027 Write 40 words with interleaved reads -> pointers wrap twice, no data loss or reorder; count never exceeds 16.
REQ-028 Fill to 7, assert rst_n=0 for one cycle -> count=0, empty=1, err flags=0; the next read gives underflow, not stale data.
